// File: rtl/fht_unload_pkg.sv
// Shared types and constants for the FHT bank unload path.
// Both the unloader and the line FIFO are sized from these.
package fht_unload_pkg;

  localparam int N_BANK    = 4;
  localparam int DEF_D_BIT = 22;

  // Unload FSM encoding, kept as plain constants for legacy tooling.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef logic [1:0] unload_st_t;
  typedef logic [N_BANK*DEF_D_BIT-1:0] bank_line_t;

  // Width of one bank line (all four bank words side by side).
  function automatic int line_bits(input int d_bit);
    return N_BANK * d_bit;
  endfunction

endpackage

// File: rtl/fht_unload_if.sv
// Bank read port plus output valid/ready stream of the FHT unloader.
// master = the unloader, slave = banks and downstream consumer.
interface fht_unload_if #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 22
);
  logic             start;
  logic             sel_b;
  logic             rd_en;
  logic [A_BIT-1:0] addr_rd;
  logic             rd_sel_b;
  logic [D_BIT-1:0] data_0;
  logic [D_BIT-1:0] data_1;
  logic [D_BIT-1:0] data_2;
  logic [D_BIT-1:0] data_3;
  logic [D_BIT-1:0] data;
  logic [A_BIT+1:0] index;
  logic             valid;
  logic             ready;
  logic             last;
  logic             rdy;

  modport master (
    input  start, sel_b, data_0, data_1, data_2, data_3, ready,
    output rd_en, addr_rd, rd_sel_b, data, index, valid, last, rdy
  );

  modport slave (
    output start, sel_b, data_0, data_1, data_2, data_3, ready,
    input  rd_en, addr_rd, rd_sel_b, data, index, valid, last, rdy
  );
endinterface

// File: rtl/fht_unload_line_fifo.sv
// Two-entry synchronous FIFO of bank lines, shared by loader and unloader,
// plus its protocol checker.
module fht_line_fifo #(
  parameter int W = 88
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;
  logic         do_push_s;
  logic         do_pop_s;

  // Qualify requests; a push into a full FIFO is allowed only alongside a pop.
  always_comb begin
    do_pop_s  = pop && (count_r != 2'd0);
    do_push_s = push && ((count_r != 2'd2) || do_pop_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

  fht_line_fifo_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .count (count_r)
  );
endmodule

module fht_line_fifo_chk (
  input logic       clk,
  input logic       rst,
  input logic       push,
  input logic       pop,
  input logic [1:0] count
);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == 2'd2)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && (count == 2'd0)));
endmodule

// File: rtl/fht_unload.sv
// Streams a finished FHT out of the four coefficient banks in natural order,
// one sample per valid/ready beat.
module fht_unload
  import fht_unload_pkg::*;
#(
  parameter int A_BIT  = 8,
  parameter int D_BIT  = 22,
  parameter int RD_LAT = 2
) (
  input logic             clk,
  input logic             rst,
  fht_unload_if.master    bus
);
  localparam int LW = line_bits(D_BIT);
  localparam int NB = A_BIT + 2;

  unload_st_t        state_r;
  logic              sel_b_r;
  logic [A_BIT-1:0]  addr_r;
  logic [NB-1:0]     idx_r;
  logic [RD_LAT-1:0] pipe_r;

  logic [LW-1:0]     head_s;
  logic [LW-1:0]     push_line_s;
  logic [1:0]        fifo_cnt_s;
  logic [1:0]        inflight_s;
  logic [D_BIT-1:0]  data_s;
  logic              rd_en_s;
  logic              push_s;
  logic              pop_s;
  logic              valid_s;
  logic              xfer_s;
  logic              last_s;

  // Issue/handshake decode; at most two lines are ever buffered or in flight.
  always_comb begin
    inflight_s = 2'd0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_s = inflight_s + {1'b0, pipe_r[i]};
    end
    rd_en_s     = (state_r == ST_RUN) &&
                  (({1'b0, fifo_cnt_s} + {1'b0, inflight_s}) < 3'd2);
    push_s      = pipe_r[RD_LAT-1];
    push_line_s = {bus.data_3, bus.data_2, bus.data_1, bus.data_0};
    valid_s     = (fifo_cnt_s != 2'd0);
    xfer_s      = valid_s && bus.ready;
    pop_s       = xfer_s && (idx_r[1:0] == 2'b11);
    last_s      = valid_s && (idx_r == {NB{1'b1}});
  end

  // Word select; lines always start at index 0, so idx[1:0] is the word pointer.
  always_comb begin
    case (idx_r[1:0])
      2'd0:    data_s = head_s[0*D_BIT +: D_BIT];
      2'd1:    data_s = head_s[1*D_BIT +: D_BIT];
      2'd2:    data_s = head_s[2*D_BIT +: D_BIT];
      default: data_s = head_s[3*D_BIT +: D_BIT];
    endcase
  end

  // FSM, read address, output index and read-latency pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sel_b_r <= 1'b0;
      addr_r  <= '0;
      idx_r   <= '0;
      pipe_r  <= '0;
    end else begin
      pipe_r <= (pipe_r << 1) | RD_LAT'(rd_en_s);
      if (rd_en_s) begin
        addr_r <= addr_r + A_BIT'(1);
      end
      if (xfer_s) begin
        idx_r <= idx_r + NB'(1);
      end
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r <= ST_RUN;
            sel_b_r <= bus.sel_b;
            addr_r  <= '0;
            idx_r   <= '0;
          end
        end
        ST_RUN: begin
          if (rd_en_s && (addr_r == {A_BIT{1'b1}})) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (xfer_s && last_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  fht_line_fifo #(.W(LW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_line_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (fifo_cnt_s)
  );

  assign bus.rd_en    = rd_en_s;
  assign bus.addr_rd  = addr_r;
  assign bus.rd_sel_b = sel_b_r;
  assign bus.data     = data_s;
  assign bus.index    = idx_r;
  assign bus.valid    = valid_s;
  assign bus.last     = last_s;
  assign bus.rdy      = (state_r == ST_IDLE);
endmodule

// File: tb/tb_fht_unload.sv
// Bench for fht_unload: three instances (RD_LAT 1..3), each with a bank RAM
// model and a transaction-level reference model checked every cycle.
module tb_fht_unload;
  localparam int A_BIT = 2;
  localparam int D_BIT = 22;
  localparam int NPTS  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic             start_s [3];
  logic             sel_s   [3];
  logic             ready_s [3];
  logic             rdy_w   [3];
  logic             valid_w [3];
  logic             rd_en_w [3];
  logic [A_BIT+1:0] index_w [3];
  logic [D_BIT-1:0] data_w  [3];
  int               reads_w [3];

  function automatic void check(input string name, input int inst,
                                input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (RD_LAT=%0d): got %0d, expected %0d", name, inst + 1, act, exp);
    end
  endfunction

  // Bank k word a holds 100*k+a; set B adds 1000.
  function automatic logic [D_BIT-1:0] bank_val(input logic sel, input int k, input int a);
    return D_BIT'(1000 * int'(sel) + 100 * k + a);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_lat
    localparam int LAT = g + 1;

    fht_unload_if #(.A_BIT(A_BIT), .D_BIT(D_BIT)) bus ();

    fht_unload #(.A_BIT(A_BIT), .D_BIT(D_BIT), .RD_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
    );

    assign bus.start  = start_s[g];
    assign bus.sel_b  = sel_s[g];
    assign bus.ready  = ready_s[g];
    assign rdy_w[g]   = bus.rdy;
    assign valid_w[g] = bus.valid;
    assign rd_en_w[g] = bus.rd_en;
    assign index_w[g] = bus.index;
    assign data_w[g]  = bus.data;

    // Bank RAM: data appears LAT cycles after the strobe, junk otherwise.
    logic             pv [LAT] = '{default: 1'b0};
    logic             ps [LAT];
    logic [A_BIT-1:0] pa [LAT];
    logic [D_BIT-1:0] junk [4];
    always @(posedge clk) begin
      pv[0] <= bus.rd_en;
      ps[0] <= bus.rd_sel_b;
      pa[0] <= bus.addr_rd;
      for (int s = 1; s < LAT; s++) begin
        pv[s] <= pv[s-1];
        ps[s] <= ps[s-1];
        pa[s] <= pa[s-1];
      end
      for (int k = 0; k < 4; k++) junk[k] <= D_BIT'($urandom);
    end
    assign bus.data_0 = pv[LAT-1] ? bank_val(ps[LAT-1], 0, int'(pa[LAT-1])) : junk[0];
    assign bus.data_1 = pv[LAT-1] ? bank_val(ps[LAT-1], 1, int'(pa[LAT-1])) : junk[1];
    assign bus.data_2 = pv[LAT-1] ? bank_val(ps[LAT-1], 2, int'(pa[LAT-1])) : junk[2];
    assign bus.data_3 = pv[LAT-1] ? bank_val(ps[LAT-1], 3, int'(pa[LAT-1])) : junk[3];

    // Reference model: n = beats delivered, reads = strobes seen this unload.
    logic active = 1'b0;
    logic fresh = 1'b1;
    logic sel_m = 1'b0;
    logic seen_valid = 1'b0;
    logic was_active;
    int   n = 0;
    int   reads = 0;
    int   cyc = 0;
    assign reads_w[g] = reads;

    always @(negedge clk) begin
      if (rst) begin
        active = 1'b0; fresh = 1'b1; n = 0; reads = 0; seen_valid = 1'b0;
      end else begin
        was_active = active;
        check("rdy", g, bus.rdy, !active);
        if (fresh) begin
          check("reset_index", g, bus.index, 0);
          check("reset_data", g, bus.data, 0);
          check("reset_addr", g, bus.addr_rd, 0);
          check("reset_last", g, bus.last, 0);
          check("reset_rd_sel", g, bus.rd_sel_b, 0);
        end
        if (!active) begin
          check("valid_idle", g, bus.valid, 0);
          check("rd_en_idle", g, bus.rd_en, 0);
        end else begin
          cyc++;
          if (bus.rd_en) begin
            check("rd_addr", g, bus.addr_rd, reads);
            check("rd_sel_b", g, bus.rd_sel_b, sel_m);
            reads++;
          end
          check("outstanding_le2", g, (reads - n / 4) <= 2, 1);
          if (seen_valid) check("valid_contiguous", g, bus.valid, 1);
          if (bus.valid) begin
            if (!seen_valid) begin
              // Edges from the accepting edge to the first valid cycle.
              check("first_valid_latency", g, cyc, LAT + 1);
              seen_valid = 1'b1;
            end
            check("index", g, bus.index, n);
            check("data", g, bus.data, bank_val(sel_m, n % 4, n / 4));
            check("last", g, bus.last, n == NPTS - 1);
            if (bus.ready) begin
              if (!sel_m && n == 5) check("pin_setA_n5", g, bus.data, 22'd101);
              if (sel_m && n == 14) check("pin_setB_n14", g, bus.data, 22'd1203);
              n++;
              if (n == NPTS) begin
                check("reads_per_unload", g, reads, NPTS / 4);
                active = 1'b0;
              end
            end
          end
        end
        if (!was_active && start_s[g]) begin
          active = 1'b1; fresh = 1'b0; sel_m = sel_s[g];
          n = 0; reads = 0; cyc = -1; seen_valid = 1'b0;
        end
      end
    end
  end

  task automatic start_insts(input logic [2:0] mask, input logic sel);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) if (mask[i]) begin start_s[i] = 1'b1; sel_s[i] = sel; end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) start_s[i] = 1'b0;
  endtask

  // mode 0: ready=1, 1: toggling 1010.., 2: random
  task automatic wait_insts(input logic [2:0] mask, input int mode, input int bound);
    logic done;
    done = 1'b0;
    for (int c = 0; c < bound && !done; c++) begin
      for (int i = 0; i < 3; i++)
        ready_s[i] = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
      @(negedge clk);
      done = 1'b1;
      for (int i = 0; i < 3; i++) if (mask[i] && !rdy_w[i]) done = 1'b0;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) ready_s[i] = 1'b1;
    check("finish_in_bound", 0, done, 1'b1);
  endtask

  initial begin
    logic found;
    for (int i = 0; i < 3; i++) begin start_s[i] = 1'b0; sel_s[i] = 1'b0; ready_s[i] = 1'b1; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Plain unload of set A at full rate.
    start_insts(3'b010, 1'b0);
    wait_insts(3'b010, 0, 200);

    // Set B with alternating ready.
    start_insts(3'b010, 1'b1);
    wait_insts(3'b010, 1, 200);

    // Long stall right after start: only two lines may be fetched.
    start_insts(3'b010, 1'b0);
    ready_s[1] = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("stall_reads", 1, reads_w[1], 2);
    check("stall_valid", 1, valid_w[1], 1);
    check("stall_data", 1, data_w[1], 22'd0);
    check("stall_index", 1, index_w[1], 0);
    wait_insts(3'b010, 0, 200);

    // Second start during RUN must be ignored.
    start_insts(3'b010, 1'b0);
    repeat (3) @(posedge clk);
    start_insts(3'b010, 1'b1);
    wait_insts(3'b010, 0, 200);
    repeat (10) @(posedge clk);

    // Reset in the middle of the stream.
    start_insts(3'b010, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (valid_w[1] && index_w[1] == 4'd7) found = 1'b1;
    end
    check("reached_beat7", 1, found, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_valid", 1, valid_w[1], 0);
    check("post_reset_rdy", 1, rdy_w[1], 1);
    check("post_reset_rd_en", 1, rd_en_w[1], 0);
    start_insts(3'b010, 1'b0);
    wait_insts(3'b010, 0, 200);

    // Latency sweep on all three instances, then randomized unloads.
    start_insts(3'b111, 1'b0);
    wait_insts(3'b111, 0, 200);
    repeat (8) begin
      start_insts(3'b111, 1'($urandom_range(0, 1)));
      wait_insts(3'b111, 2, 400);
    end
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
